spi_dda_host: RTL and testbench

SPI initiator that drives the DDA core's 32-bit SPI responder from a host-side controller (test FPGA / companion logic). Each `start` runs one chip-select-framed, mode-0, MSB-first 32-bit exchange: `tx_word` goes out on `mosi`, the returned word is captured into `rx_word`, and a one-cycle `done` is pulsed. Each transaction also steps the DDA one half-clock, because the responder toggles the DDA clock on every cs_n falling edge. `tx_word[15:0]` carries the new mu; `rx_word[31:16]` is x and `rx_word[15:0]` is y.

---
 rtl/spi_dda_pkg.sv | 21 ++
 rtl/spi_dda_host_tick.sv | 31 +++
 rtl/spi_dda_host.sv | 146 ++++++++++++++
 tb/tb_spi_dda_host.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dda_pkg.sv
// Shared constants and FSM state type for the DDA SPI host.
// Field positions describe how x/y/mu sit in the 32-bit frame.
package spi_dda_pkg;

  localparam int WORD_BITS = 32;
  localparam int DEFAULT_CLK_DIV = 4;

  localparam int X_MSB = 31;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_dda_host_tick.sv
// Free-running divide-by-DIV counter; tick marks the last cycle
// of every SCK half-period. clear realigns it to a frame start.
module spi_half_tick
  import spi_dda_pkg::*;
#(
  parameter int DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dda_host.sv
// Mode-0 32-bit SPI initiator stepping the DDA core once per frame.
// All outputs come straight from flops.
module spi_dda_host
  import spi_dda_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] tx_word,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

  state_t               state, state_d;
  logic [4:0]           bit_cnt, bit_d;
  logic [WORD_BITS-1:0] tx_sh, tx_d;
  logic [WORD_BITS-1:0] rx_sh, rx_d;
  logic [WORD_BITS-1:0] rx_word_d;
  logic                 cs_n_d, sclk_d, mosi_d;
  logic                 busy_d, done_d;
  logic                 accept;
  logic                 tick;

  spi_half_tick #(
    .DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    state_d   = state;
    bit_d     = bit_cnt;
    tx_d      = tx_sh;
    rx_d      = rx_sh;
    rx_word_d = rx_word;
    cs_n_d    = cs_n;
    sclk_d    = sclk;
    mosi_d    = mosi;
    busy_d    = busy;
    done_d    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d = 1'b1;
            rx_d   = {rx_sh[WORD_BITS-2:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state_d = HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_cnt + 5'd1;
              tx_d   = {tx_sh[WORD_BITS-2:0], 1'b0};
              mosi_d = tx_sh[WORD_BITS-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_word_d = rx_sh;
        end
      end
      GAP: begin
        // a held start chains frames so cs_n stays high only D cycles
        if (tick) begin
          if (start) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SETUP;
      bit_d   = '0;
      tx_d    = tx_word;
      mosi_d  = tx_word[WORD_BITS-1];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_word <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bit_cnt <= bit_d;
      tx_sh   <= tx_d;
      rx_sh   <= rx_d;
      rx_word <= rx_word_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_dda_host.sv
// Directed bench for spi_dda_host: D=4 and D=2 instances,
// loopback, responder model, chaining, async reset, protocol monitor.
module tb_spi_dda_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start4 = 1'b0;
  logic [31:0] tx4 = '0;
  logic        busy4, done4, cs_n4, sclk4, mosi4, miso4;
  logic [31:0] rx4;

  logic        start2 = 1'b0;
  logic [31:0] tx2 = '0;
  logic        busy2, done2, cs_n2, sclk2, mosi2;
  logic [31:0] rx2;

  logic        sel = 1'b0;
  logic [31:0] resp_word = '0;
  logic [31:0] r_sh = '0;
  logic [31:0] r_cap = '0;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign miso4 = sel ? r_sh[31] : mosi4;

  spi_dda_host #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .tx_word(tx4), .busy(busy4), .done(done4),
    .rx_word(rx4), .cs_n(cs_n4), .sclk(sclk4),
    .mosi(mosi4), .miso(miso4)
  );

  spi_dda_host #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .tx_word(tx2), .busy(busy2), .done(done2),
    .rx_word(rx2), .cs_n(cs_n2), .sclk(sclk2),
    .mosi(mosi2), .miso(1'b1)
  );

  // mode-0 responder: preload on cs_n fall, capture on rise
  always @(negedge cs_n4) r_sh <= resp_word;
  always @(posedge sclk4) if (!cs_n4) r_cap <= {r_cap[30:0], mosi4};
  always @(negedge sclk4) if (!cs_n4) r_sh <= {r_sh[30:0], 1'b0};

  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  int   mon_rises = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cs_n4 !== p_cs) begin
        checks++;
        if (sclk4 !== 1'b0 || p_sclk !== 1'b0) begin
          fails++;
          $display("FAIL mon_cs_edge sclk=%b prev=%b req 0", sclk4, p_sclk);
        end
        if (cs_n4 === 1'b0) begin
          mon_rises = 0;
        end else begin
          checks++;
          if (mon_rises != 32) begin
            fails++;
            $display("FAIL mon_rises got %0d req 32", mon_rises);
          end
        end
      end
      if (sclk4 === 1'b1 && p_sclk === 1'b0) begin
        mon_rises++;
        checks++;
        if (cs_n4 !== 1'b0 || mosi4 !== p_mosi) begin
          fails++;
          $display("FAIL mon_rise cs_n=%b mosi=%b prev=%b",
                   cs_n4, mosi4, p_mosi);
        end
      end
    end
    p_cs   = cs_n4;
    p_sclk = sclk4;
    p_mosi = mosi4;
  end

  task automatic run_frame4(input logic [31:0] w,
                            output int at, output logic [31:0] r);
    at = -1;
    r  = '0;
    @(posedge clk); #1;
    start4 = 1'b1;
    tx4    = w;
    for (int n = 1; n <= 400 && at < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) start4 = 1'b0;
      if (done4 === 1'b1) begin
        at = n;
        r  = rx4;
      end
    end
    for (int n = 0; n < 20 && busy4 !== 1'b0; n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_n4, sclk4, mosi4, busy4, done4} !== 5'b10000) begin
      fails++;
      $display("FAIL reset4 outs=%b req 10000",
               {cs_n4, sclk4, mosi4, busy4, done4});
    end
    checks++;
    if (rx4 !== 32'h0 || rx2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_rx rx4=%h rx2=%h req 0", rx4, rx2);
    end
    checks++;
    if ({cs_n2, sclk2, mosi2, busy2, done2} !== 5'b10000) begin
      fails++;
      $display("FAIL reset2 outs=%b req 10000",
               {cs_n2, sclk2, mosi2, busy2, done2});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    int done_at = -1, busy_fall = -1, first_rise = -1;
    int ndone = 0, cs1 = -1;
    logic [31:0] got = '0;
    sel = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1;
    tx4    = 32'hA5A5_1234;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start4 = 1'b0;
        cs1 = {cs_n4, busy4};
      end
      if (sclk4 === 1'b1 && first_rise < 0) first_rise = n;
      if (done4 === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n;
          got = rx4;
        end
      end
      if (busy4 === 1'b0 && busy_fall < 0) busy_fall = n;
    end
    checks++;
    if (cs1 != 1) begin
      fails++;
      $display("FAIL lb_cycle1 {cs_n,busy}=%0d req 1", cs1);
    end
    checks++;
    if (first_rise != 9) begin
      fails++;
      $display("FAIL lb_first_rise got %0d req 9", first_rise);
    end
    checks++;
    if (done_at != 265) begin
      fails++;
      $display("FAIL lb_done_cycle got %0d req 265", done_at);
    end
    checks++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL lb_done_width got %0d req 1", ndone);
    end
    checks++;
    if (busy_fall != 269) begin
      fails++;
      $display("FAIL lb_busy_fall got %0d req 269", busy_fall);
    end
    checks++;
    if (got !== 32'hA5A5_1234) begin
      fails++;
      $display("FAIL lb_rx got %h req a5a51234", got);
    end
  endtask

  task automatic test_responder();
    int at;
    logic [31:0] r;
    sel = 1'b1;
    resp_word = 32'h3000_3000;
    run_frame4(32'h0000_1234, at, r);
    checks++;
    if (at != 265) begin
      fails++;
      $display("FAIL resp_done got %0d req 265", at);
    end
    checks++;
    if (r !== 32'h3000_3000) begin
      fails++;
      $display("FAIL resp_rx got %h req 30003000", r);
    end
    checks++;
    if (r_cap[15:0] !== 16'h1234 || r_cap !== 32'h0000_1234) begin
      fails++;
      $display("FAIL resp_mu got %h req 00001234", r_cap);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [31:0] got[3];
    int gaps[2];
    int nd = 0, falls = 0, ng = 0, hi = 0;
    logic pc;
    w[0] = 32'h1357_9BDF;
    w[1] = 32'h2468_ACE0;
    w[2] = 32'hDEAD_BEEF;
    got[0] = '0; got[1] = '0; got[2] = '0;
    gaps[0] = -1; gaps[1] = -1;
    sel = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1;
    tx4 = w[0];
    pc = cs_n4;
    for (int n = 1; n <= 900; n++) begin
      @(posedge clk); #1;
      if (cs_n4 === 1'b1) hi++;
      if (cs_n4 === 1'b0 && pc === 1'b1) begin
        falls++;
        if (falls > 1 && ng < 2) begin
          gaps[ng] = hi;
          ng++;
        end
        hi = 0;
      end
      pc = cs_n4;
      if (done4 === 1'b1) begin
        if (nd < 3) got[nd] = rx4;
        nd++;
      end
      if (n == 268) tx4 = w[1];
      else if (n == 536) tx4 = w[2];
      else tx4 = 32'hFFFF_0000 ^ n;
      if (n == 537) start4 = 1'b0;
      if (n == 600) start4 = 1'b1;
      if (n == 601) start4 = 1'b0;
    end
    checks++;
    if (nd != 3 || falls != 3) begin
      fails++;
      $display("FAIL b2b_frames done=%0d falls=%0d req 3", nd, falls);
    end
    checks++;
    if (gaps[0] != 4 || gaps[1] != 4) begin
      fails++;
      $display("FAIL b2b_gap got %0d,%0d req 4", gaps[0], gaps[1]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k] !== w[k]) begin
        fails++;
        $display("FAIL b2b_rx%0d got %h req %h", k, got[k], w[k]);
      end
    end
    checks++;
    if (busy4 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle busy=%b req 0", busy4);
    end
  endtask

  task automatic test_div2();
    int done_at = -1, rises = 0, bad = 0, hl = 0;
    logic [31:0] got = '0;
    logic ps = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1;
    tx2 = 32'h0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) start2 = 1'b0;
      if (sclk2 === 1'b1) begin
        if (!ps) rises++;
        hl++;
      end else begin
        if (ps && hl != 2) bad++;
        hl = 0;
      end
      ps = sclk2;
      if (done2 === 1'b1 && done_at < 0) begin
        done_at = n;
        got = rx2;
      end
    end
    checks++;
    if (done_at != 133) begin
      fails++;
      $display("FAIL d2_done got %0d req 133", done_at);
    end
    checks++;
    if (got !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL d2_rx got %h req ffffffff", got);
    end
    checks++;
    if (rises != 32 || bad != 0) begin
      fails++;
      $display("FAIL d2_sclk rises=%0d bad=%0d req 32,0", rises, bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int at;
    logic [31:0] r;
    logic hi10;
    sel = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1;
    tx4 = 32'hCAFE_F00D;
    for (int n = 1; n <= 90; n++) begin
      @(posedge clk); #1;
      if (n == 1) start4 = 1'b0;
    end
    hi10 = sclk4;
    checks++;
    if (hi10 !== 1'b1 || cs_n4 !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre sclk=%b cs_n=%b req 1,0", hi10, cs_n4);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_n4, sclk4, mosi4, busy4, done4} !== 5'b10000) begin
      fails++;
      $display("FAIL mid_rst outs=%b req 10000",
               {cs_n4, sclk4, mosi4, busy4, done4});
    end
    checks++;
    if (rx4 !== 32'h0 || rx2 !== 32'h0) begin
      fails++;
      $display("FAIL mid_rst_rx rx4=%h rx2=%h req 0", rx4, rx2);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done4 !== 1'b0 || cs_n4 !== 1'b1) begin
      fails++;
      $display("FAIL mid_hold done=%b cs_n=%b req 0,1", done4, cs_n4);
    end
    @(negedge clk) rst_n = 1'b1;
    run_frame4(32'h0F0F_5A5A, at, r);
    checks++;
    if (at != 265 || r !== 32'h0F0F_5A5A) begin
      fails++;
      $display("FAIL mid_after at=%0d rx=%h req 265,0f0f5a5a", at, r);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_responder();
    test_back_to_back();
    test_div2();
    test_reset_mid_frame();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
